// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM state encoding and port IDs for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// mem_port_arbiter_rr_pick2: combinational 2-way round-robin selector
//  i_req, d_req : requests      last_gnt : port granted last (0 = I, 1 = D)
//  any          : some request  win      : winning port (0 = I, 1 = D)
module mem_port_arbiter_rr_pick2 (
  input  logic i_req,
  input  logic d_req,
  input  logic last_gnt,
  output logic any,
  output logic win
);
  assign any = i_req | d_req;
  assign win = (i_req && d_req) ? ~last_gnt : d_req;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one fixed-latency memory port between fetch (I) and load/store (D)
//  clk, reset (async, active low)
//  I side : i_req, i_addr -> i_ack, i_rdata
//  D side : d_req, d_we, d_addr, d_wdata -> d_ack, d_rdata
//  memory : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata (valid MEM_LAT cycles after mem_en)
//  ARB_STATS_EN : adds saturating counters stat_i_gnt, stat_d_gnt, stat_conflict
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
`ifdef ARB_STATS_EN
  output logic [15:0]   stat_i_gnt,
  output logic [15:0]   stat_d_gnt,
  output logic [15:0]   stat_conflict,
`endif
  input  logic [DW-1:0] mem_rdata
);
  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);
  state_t state_q, state_d;
  logic win_q, win_d, last_q, last_d, any, win;
  logic [2:0] cnt_q, cnt_d;
  logic mem_en_q, mem_en_d, mem_we_q, mem_we_d, i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  mem_port_arbiter_rr_pick2 u_pick (
    .i_req   (i_req),
    .d_req   (d_req),
    .last_gnt(last_q),
    .any     (any),
    .win     (win)
  );
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      ST_IDLE: if (any) begin
        state_d     = ST_ISSUE;
        win_d       = win;
        last_d      = win;
        mem_en_d    = 1'b1;
        mem_we_d    = (win == PORT_D) && d_we;
        mem_addr_d  = (win == PORT_D) ? d_addr : i_addr;
        mem_wdata_d = (win == PORT_D) ? d_wdata : '0;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = LAT_M1;
      end
      ST_WAIT: if (cnt_q == 3'd0) begin
        // read data is on mem_rdata this cycle; ack and data become visible together
        state_d   = ST_DONE;
        i_ack_d   = win_q == PORT_I;
        d_ack_d   = win_q == PORT_D;
        i_rdata_d = (win_q == PORT_I) ? mem_rdata : i_rdata_q;
        d_rdata_d = (win_q == PORT_D && !mem_we_q) ? mem_rdata : d_rdata_q;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      win_q       <= PORT_I;
      last_q      <= PORT_D;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
`ifdef ARB_STATS_EN
  logic grant, conflict;
  logic [15:0] stat_i_gnt_q, stat_i_gnt_d, stat_d_gnt_q, stat_d_gnt_d, stat_conflict_q, stat_conflict_d;
  // counters stick at all-ones instead of wrapping
  always_comb begin
    grant           = state_q == ST_IDLE && any;
    conflict        = state_q == ST_IDLE && i_req && d_req;
    stat_i_gnt_d    = stat_i_gnt_q + 16'(grant && win == PORT_I && stat_i_gnt_q != 16'hFFFF);
    stat_d_gnt_d    = stat_d_gnt_q + 16'(grant && win == PORT_D && stat_d_gnt_q != 16'hFFFF);
    stat_conflict_d = stat_conflict_q + 16'(conflict && stat_conflict_q != 16'hFFFF);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_i_gnt_q    <= '0;
      stat_d_gnt_q    <= '0;
      stat_conflict_q <= '0;
    end else begin
      stat_i_gnt_q    <= stat_i_gnt_d;
      stat_d_gnt_q    <= stat_d_gnt_d;
      stat_conflict_q <= stat_conflict_d;
    end
  end
  assign stat_i_gnt    = stat_i_gnt_q;
  assign stat_d_gnt    = stat_d_gnt_q;
  assign stat_conflict = stat_conflict_q;
`endif
endmodule
